// File: rtl/wb_stage_pkg.sv
// Shared definitions for the rv32i writeback stage: instruction classes,
// load funct3 encodings and the writeback FSM state encoding.
package wb_stage_pkg;

   // Instruction-class codes shared with the execute stage.
   localparam logic [3:0] R_TYPE = 4'd0;
   localparam logic [3:0] I_TYPE = 4'd1;
   localparam logic [3:0] L_TYPE = 4'd2;
   localparam logic [3:0] S_TYPE = 4'd3;
   localparam logic [3:0] B_TYPE = 4'd4;
   localparam logic [3:0] U_TYPE = 4'd5;
   localparam logic [3:0] J_TYPE = 4'd6;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Handshake, load-return, register-file and bypass signals of the writeback
// stage. The memory stage side is the master; wb_stage is the slave.
interface wb_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TYPE_W     = 4,
   parameter int CNT_W      = 32
);

   logic                  in_valid;
   logic                  in_ready;
   logic [TYPE_W-1:0]     insn_type;
   logic [2:0]            funct3;
   logic [1:0]            addr_lo;
   logic [REG_ADDR_W-1:0] rd;
   logic [XLEN-1:0]       ex_val;
   logic                  mem_r_valid;
   logic [31:0]           mem_r_data;
   logic                  regfile_w_en;
   logic [REG_ADDR_W-1:0] regfile_w_reg;
   logic [XLEN-1:0]       regfile_w_data;
   logic                  wb_bp_valid;
   logic [REG_ADDR_W-1:0] wb_bp_reg;
   logic [XLEN-1:0]       wb_bp_val;
   logic [CNT_W-1:0]      retired_cnt;

   modport slave (
      input  in_valid,
      output in_ready,
      input  insn_type,
      input  funct3,
      input  addr_lo,
      input  rd,
      input  ex_val,
      input  mem_r_valid,
      input  mem_r_data,
      output regfile_w_en,
      output regfile_w_reg,
      output regfile_w_data,
      output wb_bp_valid,
      output wb_bp_reg,
      output wb_bp_val,
      output retired_cnt
   );

   modport master (
      output in_valid,
      input  in_ready,
      output insn_type,
      output funct3,
      output addr_lo,
      output rd,
      output ex_val,
      output mem_r_valid,
      output mem_r_data,
      input  regfile_w_en,
      input  regfile_w_reg,
      input  regfile_w_data,
      input  wb_bp_valid,
      input  wb_bp_reg,
      input  wb_bp_val,
      input  retired_cnt
   );

endinterface

// File: rtl/wb_stage_load_extract.sv
// Combinational load alignment: picks the byte/halfword/word out of the raw
// memory word and sign- or zero-extends it to XLEN (XLEN must be >= 32).
module wb_stage_load_extract
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [31:0]     mem_r_data_i,
   output logic [XLEN-1:0] load_val_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_r_data_i[7:0];
      case (addr_lo_i)
         2'd0: byte_sel = mem_r_data_i[7:0];
         2'd1: byte_sel = mem_r_data_i[15:8];
         2'd2: byte_sel = mem_r_data_i[23:16];
         2'd3: byte_sel = mem_r_data_i[31:24];
         default: byte_sel = mem_r_data_i[7:0];
      endcase
   end

   // Halfword loads ignore the odd-byte bit of the address.
   assign half_sel = addr_lo_i[1] ? mem_r_data_i[31:16] : mem_r_data_i[15:0];

   always_comb begin
      load_val_o = XLEN'($signed(mem_r_data_i));
      case (funct3_i)
         F3_LB:   load_val_o = XLEN'($signed(byte_sel));
         F3_LBU:  load_val_o = XLEN'(byte_sel);
         F3_LH:   load_val_o = XLEN'($signed(half_sel));
         F3_LHU:  load_val_o = XLEN'(half_sel);
         F3_LW:   load_val_o = XLEN'($signed(mem_r_data_i));
         default: load_val_o = XLEN'($signed(mem_r_data_i));
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rv32i writeback stage: accepts one instruction per handshake, waits for load
// data if needed, and issues one registered regfile write/bypass per retire.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new instruction; retires non-loads and loads
//         | whose data arrives in the accept cycle
// ST_WAIT | load accepted, holding its fields until mem_r_valid
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TYPE_W     = 4,
   parameter int CNT_W      = 32
) (
   input logic        clk,
   input logic        rst,
   wb_stage_if.slave  bus
);

   wb_state_e             state_q, state_d;

   logic [TYPE_W-1:0]     type_q;
   logic [2:0]            funct3_q;
   logic [1:0]            addr_lo_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       ex_val_q;

   logic                  wen_q, wen_d;
   logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  in_ready;
   logic                  accept;
   logic                  retire;
   logic                  in_is_load;
   logic                  use_held;

   logic [TYPE_W-1:0]     cur_type;
   logic [2:0]            cur_funct3;
   logic [1:0]            cur_addr_lo;
   logic [REG_ADDR_W-1:0] cur_rd;
   logic [XLEN-1:0]       cur_ex_val;
   logic                  cur_is_load;
   logic                  cur_writes_rd;
   logic [XLEN-1:0]       load_val;
   logic [XLEN-1:0]       result;

   assign in_ready   = !rst && (state_q == ST_IDLE);
   assign accept     = bus.in_valid && in_ready;
   assign in_is_load = (bus.insn_type == TYPE_W'(L_TYPE));

   // In WAIT the retiring instruction lives in the holding registers; in IDLE
   // it is the one being accepted this cycle.
   assign use_held    = (state_q == ST_WAIT);
   assign cur_type    = use_held ? type_q    : bus.insn_type;
   assign cur_funct3  = use_held ? funct3_q  : bus.funct3;
   assign cur_addr_lo = use_held ? addr_lo_q : bus.addr_lo;
   assign cur_rd      = use_held ? rd_q      : bus.rd;
   assign cur_ex_val  = use_held ? ex_val_q  : bus.ex_val;

   assign cur_is_load   = (cur_type == TYPE_W'(L_TYPE));
   assign cur_writes_rd = !((cur_type == TYPE_W'(S_TYPE)) ||
                            (cur_type == TYPE_W'(B_TYPE)));

   wb_stage_load_extract #(
      .XLEN (XLEN)
   ) u_load_extract (
      .funct3_i     (cur_funct3),
      .addr_lo_i    (cur_addr_lo),
      .mem_r_data_i (bus.mem_r_data),
      .load_val_o   (load_val)
   );

   assign result = cur_is_load ? load_val : cur_ex_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_is_load && !bus.mem_r_valid) begin
                  state_d = ST_WAIT;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (bus.mem_r_valid) begin
               retire  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         type_q    <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         rd_q      <= '0;
         ex_val_q  <= '0;
      end else if (accept) begin
         type_q    <= bus.insn_type;
         funct3_q  <= bus.funct3;
         addr_lo_q <= bus.addr_lo;
         rd_q      <= bus.rd;
         ex_val_q  <= bus.ex_val;
      end
   end

   // Index/data only move on a real strobe; stores, branches and x0 writes
   // still count as retired.
   always_comb begin
      wen_d   = retire && cur_writes_rd && (cur_rd != '0);
      wreg_d  = wen_d ? cur_rd : wreg_q;
      wdata_d = wen_d ? result : wdata_q;
      cnt_d   = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         wen_q   <= wen_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.regfile_w_en   = wen_q;
   assign bus.regfile_w_reg  = wreg_q;
   assign bus.regfile_w_data = wdata_q;
   assign bus.wb_bp_valid    = wen_q;
   assign bus.wb_bp_reg      = wreg_q;
   assign bus.wb_bp_val      = wdata_q;
   assign bus.retired_cnt    = cnt_q;

endmodule
